ram8_word_ctrl: RTL and testbench
=================================

Name: ram8_word_ctrl

Overview:
- Sequencer that gives a 32-bit load/store port on top of one byte-wide synchronous RAM.
  - RAM port: write-enable, read-enable, shared address, 1-cycle registered read.
- Splits byte, halfword and word requests into consecutive byte accesses, little-endian.
- Reassembles read data with sign or zero extension. Rejects misaligned or reserved-size requests without touching the RAM.
- Sits between the core's data-memory stage and the byte RAM instance.

Parameters:
- SIZE_BYTE, 2048, RAM capacity in bytes; power of two.
- ADDRWIDTH (localparam), $clog2(SIZE_BYTE), byte address width.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  controller can accept a request
- i_req_we  in  1  1 = store, 0 = load
- i_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- i_req_unsigned  in  1  load: zero-extend when 1, sign-extend when 0
- i_req_addr  in  ADDRWIDTH  byte address
- i_req_wd  in  32  store data, low bytes used
- o_resp_valid  out  1  one-cycle completion pulse
- o_resp_err  out  1  qualifies o_resp_valid: misaligned or reserved size
- o_resp_rd  out  32  load result; 0 for stores and errors
- o_ram_we  out  1  to RAM write enable
- o_ram_re  out  1  to RAM read enable
- o_ram_addr  out  ADDRWIDTH  to RAM address
- o_ram_wd  out  8  to RAM write data
- i_ram_rd  in  8  from RAM read data, valid the cycle after o_ram_re

Behaviour:
- Reset values: all outputs 0 except o_req_ready = 1; state IDLE; byte counter 0; assembly register 0.
- Reset mid-operation:
  - Next edge forces IDLE and clears RAM enables.
  - Bytes already written stay written.
  - No response is issued for the aborted request.
- States:
  - IDLE → ACCESS, or → RESP on error.
  - ACCESS → DRAIN on a load, or → RESP on a store.
  - DRAIN → RESP.
  - RESP → IDLE.
- Accepting a request:
  - o_req_ready = 1 only in IDLE.
  - Accept on i_req_valid & o_req_ready at edge T0; latch we, size, unsigned, addr and wd.
  - N = 1, 2 or 4 bytes for size 0, 1 or 2.
- Error check, done at accept:
  - Errors: size 3; half with addr[0] = 1; word with addr[1:0] ≠ 0.
  - On error go straight to RESP.
  - Response: o_resp_valid = 1, o_resp_err = 1, o_resp_rd = 0 in cycle T1.
  - No RAM enable is asserted.
- ACCESS phase:
  - Runs for cycles T1..TN; cycle Tk addresses base + (k−1).
  - Store: o_ram_we = 1, o_ram_wd = wd[8(k−1)+7 : 8(k−1)].
  - Load: o_ram_re = 1.
  - Aligned accesses never cross the top of the array, so there is no address wrap.
- Load capture:
  - i_ram_rd sampled in T2..TN+1 into byte lane k−1.
  - DRAIN covers the TN+1 capture.
- Response timing:
  - Store: RESP in TN+1, so latency from accept is N+1 cycles.
  - Load: RESP in TN+2, so latency is N+2 cycles.
  - o_resp_err = 0 in both cases.
- Extension of load data:
  - Byte and half results are sign-extended from bit 7 or 15 unless unsigned.
  - Word results are passed through.
  - Stores return o_resp_rd = 0.
- Response handshake:
  - o_resp_valid is a single-cycle pulse with no backpressure; the requester must sample it.
  - o_req_ready returns to 1 in the cycle after RESP.
  - Back-to-back requests therefore have a 1-cycle gap minimum.
- RAM enables:
  - o_ram_we and o_ram_re are never both 1.
  - Both are 0 outside ACCESS.
  - o_ram_addr and o_ram_wd hold their last value when idle.
- Input rules:
  - Request inputs are ignored while o_req_ready = 0.
  - i_req_valid may drop without penalty before acceptance.

Decomposition:
- Package ram8_ctrl_pkg:
  - size encoding enum: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD.
  - state enum: IDLE, ACCESS, DRAIN, RESP.
  - function returning byte count for a size.
  - function for the misalignment check.
- Single module; no sub-module.
- Bench instantiates the existing byte RAM behind it.

Test Plan:
- Store word 0xDEADBEEF at addr 0x010 → o_ram_we on 4 cycles at 0x010..0x013 with bytes EF, BE, AD, DE. o_resp_valid 5 cycles after accept with rd = 0.
- Load word from 0x010 after the above → o_ram_re on 4 cycles, resp in T6 with rd = 0xDEADBEEF, err = 0.
- Signed byte load from 0x013 → rd = 0xFFFFFFDE. Unsigned byte load → rd = 0x000000DE. Both respond in T3.
- Half store 0x8001 at 0x7FE (top of 2048-byte RAM), then signed half load → rd = 0xFFFF8001. Unsigned half load → rd = 0x00008001. Addresses used are 0x7FE and 0x7FF only.
- Word load at 0x011, half at 0x005, size 3 at 0x000 → each gives resp in T1 with err = 1, rd = 0. No RAM enable ever asserted.
- Assert i_rst during T2 of a word store to 0x020 with data 0x11223344:
  - Next cycle: IDLE, ready = 1, no response.
  - Subsequent byte loads: 0x020 = 0x44, 0x021 = 0x33, bytes 0x022..0x023 unchanged from their prior values.

Source files
------------

// File: rtl/ram8_ctrl_pkg.sv
// ram8_ctrl_pkg
//   Shared types and helpers for the byte-RAM load/store sequencer.
//   - size_e  : request size encoding (byte / half / word / reserved)
//   - state_e : sequencer states
//   - size_nbytes   : number of byte accesses a size needs
//   - is_misaligned : alignment / reserved-size error check
package ram8_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Byte accesses needed for a request; reserved size needs none.
  function automatic logic [2:0] size_nbytes(input size_e sz);
    logic [2:0] n;
    case (sz)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // True when the request must be rejected: reserved size, or an address
  // that is not a multiple of the access size.
  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lsb);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lsb[0];
      SZ_WORD: bad = |lsb;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ram8_word_ctrl.sv
// ram8_word_ctrl
//   Gives a 32-bit load/store port on top of one byte-wide synchronous RAM
//   (1-cycle registered read). Requests are split into consecutive
//   little-endian byte accesses; load data is reassembled and sign- or
//   zero-extended. Misaligned and reserved-size requests are answered with
//   an error response without touching the RAM.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_*             request: valid, we, size, unsigned, addr, wd
//   o_req_ready         high only in IDLE
//   o_resp_valid/err/rd one-cycle completion pulse, error flag, load data
//   o_ram_we/re/addr/wd byte RAM command
//   i_ram_rd            byte RAM read data, valid the cycle after o_ram_re
module ram8_word_ctrl
  import ram8_ctrl_pkg::*;
#(
  parameter int  SIZE_BYTE = 2048,
  localparam int ADDRWIDTH = $clog2(SIZE_BYTE)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_we,
  input  logic [1:0]           i_req_size,
  input  logic                 i_req_unsigned,
  input  logic [ADDRWIDTH-1:0] i_req_addr,
  input  logic [31:0]          i_req_wd,
  output logic                 o_resp_valid,
  output logic                 o_resp_err,
  output logic [31:0]          o_resp_rd,
  output logic                 o_ram_we,
  output logic                 o_ram_re,
  output logic [ADDRWIDTH-1:0] o_ram_addr,
  output logic [7:0]           o_ram_wd,
  input  logic [7:0]           i_ram_rd
);

  state_e                r_state;
  state_e                w_state_next;
  logic                  r_we;
  size_e                 r_size;
  logic                  r_uns;
  logic                  r_err;
  logic [31:0]           r_wd;
  logic [1:0]            r_cnt;
  logic [31:0]           r_asm;
  logic                  r_cap_pend;
  logic [1:0]            r_cap_lane;
  logic [ADDRWIDTH-1:0]  r_ram_addr;
  logic [7:0]            r_ram_wd;

  logic                  w_accept;
  logic                  w_req_err;
  logic [2:0]            w_nbytes;
  logic                  w_last;
  logic [1:0]            w_cnt_inc;
  logic                  w_ram_we;
  logic                  w_ram_re;
  logic [31:0]           w_ext;

  assign w_accept  = i_req_valid && (r_state == IDLE);
  assign w_req_err = is_misaligned(size_e'(i_req_size), i_req_addr[1:0]);
  assign w_nbytes  = size_nbytes(r_size);
  assign w_last    = ({1'b0, r_cnt} == (w_nbytes - 3'd1));
  assign w_cnt_inc = r_cnt + 2'd1;
  assign w_ram_we  = (r_state == ACCESS) && r_we;
  assign w_ram_re  = (r_state == ACCESS) && !r_we;

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_req_err ? RESP : ACCESS;
      ACCESS:  if (w_last)   w_state_next = r_we ? RESP : DRAIN;
      DRAIN:   w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_size     <= SZ_BYTE;
      r_uns      <= 1'b0;
      r_err      <= 1'b0;
      r_wd       <= '0;
      r_cnt      <= '0;
      r_asm      <= '0;
      r_cap_pend <= 1'b0;
      r_cap_lane <= '0;
      r_ram_addr <= '0;
      r_ram_wd   <= '0;
    end else begin
      r_state    <= w_state_next;
      // Read data lags the read command by one cycle; remember which lane
      // the byte returning next cycle belongs to.
      r_cap_pend <= w_ram_re;
      r_cap_lane <= r_cnt;
      if (r_cap_pend) r_asm[{r_cap_lane, 3'b000} +: 8] <= i_ram_rd;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we   <= i_req_we;
            r_size <= size_e'(i_req_size);
            r_uns  <= i_req_unsigned;
            r_err  <= w_req_err;
            r_wd   <= i_req_wd;
            r_cnt  <= '0;
            r_asm  <= '0;
            // Rejected requests leave the RAM command bus untouched.
            if (!w_req_err) begin
              r_ram_addr <= i_req_addr;
              r_ram_wd   <= i_req_wd[7:0];
            end
          end
        end
        ACCESS: begin
          if (!w_last) begin
            r_cnt      <= w_cnt_inc;
            r_ram_addr <= r_ram_addr + ADDRWIDTH'(1);
            r_ram_wd   <= r_wd[{w_cnt_inc, 3'b000} +: 8];
          end
        end
        default: ;
      endcase
    end
  end

  // Load result extension
  always_comb begin
    case (r_size)
      SZ_BYTE: w_ext = r_uns ? {24'h0, r_asm[7:0]}  : {{24{r_asm[7]}}, r_asm[7:0]};
      SZ_HALF: w_ext = r_uns ? {16'h0, r_asm[15:0]} : {{16{r_asm[15]}}, r_asm[15:0]};
      default: w_ext = r_asm;
    endcase
  end

  assign o_req_ready  = (r_state == IDLE);
  assign o_resp_valid = (r_state == RESP);
  assign o_resp_err   = (r_state == RESP) && r_err;
  assign o_resp_rd    = ((r_state == RESP) && !r_err && !r_we) ? w_ext : 32'h0;
  assign o_ram_we     = w_ram_we;
  assign o_ram_re     = w_ram_re;
  assign o_ram_addr   = r_ram_addr;
  assign o_ram_wd     = r_ram_wd;

endmodule

// File: tb/tb_ram8_word_ctrl.sv
// Testbench for ram8_word_ctrl with a behavioural 2048-byte RAM behind it.
module tb_ram8_word_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [10:0] req_addr;
  logic [31:0] req_wd;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rd;
  logic        ram_we;
  logic        ram_re;
  logic [10:0] ram_addr;
  logic [7:0]  ram_wd;
  logic [7:0]  ram_rd;

  int checks;
  int errors;

  ram8_word_ctrl #(.SIZE_BYTE(2048)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_size     (req_size),
    .i_req_unsigned (req_unsigned),
    .i_req_addr     (req_addr),
    .i_req_wd       (req_wd),
    .o_resp_valid   (resp_valid),
    .o_resp_err     (resp_err),
    .o_resp_rd      (resp_rd),
    .o_ram_we       (ram_we),
    .o_ram_re       (ram_re),
    .o_ram_addr     (ram_addr),
    .o_ram_wd       (ram_wd),
    .i_ram_rd       (ram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM: synchronous write, registered read.
  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wd;
    if (ram_re) ram_rd <= mem[ram_addr];
  end

  // Log of every RAM access, sampled mid-cycle.
  typedef struct packed {
    logic        we;
    logic [10:0] addr;
    logic [7:0]  wd;
  } acc_t;
  acc_t acc_q[$];
  int   both_cnt = 0;
  always @(negedge clk) begin
    if (ram_we || ram_re) acc_q.push_back('{we: ram_we, addr: ram_addr, wd: ram_wd});
    if (ram_we && ram_re) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [10:0] addr;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_n;
  } vec_t;

  // One request: drive, accept, wait for the response, check it and the
  // RAM accesses it produced.
  task automatic do_req(input vec_t v);
    int   start;
    int   lat;
    bit   got;
    bit   seq_ok;
    acc_t a;
    logic [10:0] ea;
    got = 0;
    lat = 0;
    // wait for ready
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    check({v.name, ".ready"}, {31'h0, req_ready}, 32'h1);
    start        = acc_q.size();
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wd       = v.wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wd    = 32'hCAFE_F00D;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1;
        lat = c;
        break;
      end
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL %s.timeout: no response within 12 cycles", v.name);
    end else begin
      check({v.name, ".latency"}, lat, v.exp_lat);
      check({v.name, ".err"}, {31'h0, resp_err}, {31'h0, v.exp_err});
      check({v.name, ".rd"}, resp_rd, v.exp_rd);
      check({v.name, ".nacc"}, acc_q.size() - start, v.exp_n);
      seq_ok = 1;
      for (int k = 0; k < v.exp_n && (start + k) < acc_q.size(); k++) begin
        a  = acc_q[start + k];
        ea = v.addr + 11'(k);
        if (a.we !== v.we || a.addr !== ea || (v.we && a.wd !== v.wd[8*k +: 8])) seq_ok = 0;
      end
      check({v.name, ".accseq"}, {31'h0, seq_ok}, 32'h1);
      @(negedge clk);
      check({v.name, ".pulse_ready"}, {30'h0, resp_valid, req_ready}, 32'h1);
    end
    $display("txn %-14s we=%0d size=%0d uns=%0d addr=0x%03h lat=%0d err=%0d rd=0x%08h",
             v.name, v.we, v.size, v.uns, v.addr, lat, resp_err, resp_rd);
  endtask

  vec_t vecs[18];
  vec_t rv;
  int   rs_start;

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wd       = '0;

    //          name            we    size  uns   addr     wd             err   rd             lat n
    vecs[0]  = '{"st_w_010",    1'b1, 2'd2, 1'b0, 11'h010, 32'hDEADBEEF, 1'b0, 32'h00000000, 5, 4};
    vecs[1]  = '{"ld_w_010",    1'b0, 2'd2, 1'b0, 11'h010, 32'h0,        1'b0, 32'hDEADBEEF, 6, 4};
    vecs[2]  = '{"ld_bs_013",   1'b0, 2'd0, 1'b0, 11'h013, 32'h0,        1'b0, 32'hFFFFFFDE, 3, 1};
    vecs[3]  = '{"ld_bu_013",   1'b0, 2'd0, 1'b1, 11'h013, 32'h0,        1'b0, 32'h000000DE, 3, 1};
    vecs[4]  = '{"st_h_7fe",    1'b1, 2'd1, 1'b0, 11'h7FE, 32'hABCD8001, 1'b0, 32'h00000000, 3, 2};
    vecs[5]  = '{"ld_hs_7fe",   1'b0, 2'd1, 1'b0, 11'h7FE, 32'h0,        1'b0, 32'hFFFF8001, 4, 2};
    vecs[6]  = '{"ld_hu_7fe",   1'b0, 2'd1, 1'b1, 11'h7FE, 32'h0,        1'b0, 32'h00008001, 4, 2};
    vecs[7]  = '{"ld_w_011",    1'b0, 2'd2, 1'b0, 11'h011, 32'h0,        1'b1, 32'h00000000, 1, 0};
    vecs[8]  = '{"ld_h_005",    1'b0, 2'd1, 1'b0, 11'h005, 32'h0,        1'b1, 32'h00000000, 1, 0};
    vecs[9]  = '{"ld_s3_000",   1'b0, 2'd3, 1'b0, 11'h000, 32'h0,        1'b1, 32'h00000000, 1, 0};
    vecs[10] = '{"st_w_012",    1'b1, 2'd2, 1'b0, 11'h012, 32'h12345678, 1'b1, 32'h00000000, 1, 0};
    vecs[11] = '{"ld_bs_7ff",   1'b0, 2'd0, 1'b0, 11'h7FF, 32'h0,        1'b0, 32'hFFFFFF80, 3, 1};
    vecs[12] = '{"ld_bs_7fe",   1'b0, 2'd0, 1'b0, 11'h7FE, 32'h0,        1'b0, 32'h00000001, 3, 1};
    vecs[13] = '{"ld_hs_012",   1'b0, 2'd1, 1'b0, 11'h012, 32'h0,        1'b0, 32'hFFFFDEAD, 4, 2};
    vecs[14] = '{"ld_bu_011",   1'b0, 2'd0, 1'b1, 11'h011, 32'h0,        1'b0, 32'h000000BE, 3, 1};
    vecs[15] = '{"st_b_030",    1'b1, 2'd0, 1'b0, 11'h030, 32'h7777777F, 1'b0, 32'h00000000, 2, 1};
    vecs[16] = '{"ld_bs_030",   1'b0, 2'd0, 1'b0, 11'h030, 32'h0,        1'b0, 32'h0000007F, 3, 1};
    vecs[17] = '{"st_w_020",    1'b1, 2'd2, 1'b0, 11'h020, 32'h5A6B7C8D, 1'b0, 32'h00000000, 5, 4};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.ready",   {31'h0, req_ready}, 32'h1);
    check("rst.resp",    {30'h0, resp_valid, resp_err}, 32'h0);
    check("rst.rd",      resp_rd, 32'h0);
    check("rst.ram_en",  {30'h0, ram_we, ram_re}, 32'h0);
    check("rst.ram_bus", {13'h0, ram_addr, ram_wd}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) do_req(vecs[i]);

    // Reset during T2 of a word store to 0x020.
    @(negedge clk);
    rs_start     = acc_q.size();
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = 11'h020;
    req_wd       = 32'h11223344;
    @(posedge clk);  // T0: accept
    #1 req_valid = 1'b0;
    @(posedge clk);  // start of T2
    #1 rst = 1'b1;
    @(posedge clk);  // reset sampled
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort.ready",  {31'h0, req_ready}, 32'h1);
    check("abort.ram_en", {30'h0, ram_we, ram_re}, 32'h0);
    check("abort.nacc",   acc_q.size() - rs_start, 2);
    begin
      bit saw_resp;
      saw_resp = 0;
      for (int c = 0; c < 6; c++) begin
        if (resp_valid) saw_resp = 1;
        @(negedge clk);
      end
      check("abort.no_resp", {31'h0, saw_resp}, 32'h0);
    end
    $display("txn %-14s word store 0x020 aborted by reset in T2", "abort_st_020");

    rv = '{"ld_bu_020", 1'b0, 2'd0, 1'b1, 11'h020, 32'h0, 1'b0, 32'h00000044, 3, 1};
    do_req(rv);
    rv = '{"ld_bu_021", 1'b0, 2'd0, 1'b1, 11'h021, 32'h0, 1'b0, 32'h00000033, 3, 1};
    do_req(rv);
    rv = '{"ld_bu_022", 1'b0, 2'd0, 1'b1, 11'h022, 32'h0, 1'b0, 32'h0000006B, 3, 1};
    do_req(rv);
    rv = '{"ld_bu_023", 1'b0, 2'd0, 1'b1, 11'h023, 32'h0, 1'b0, 32'h0000005A, 3, 1};
    do_req(rv);

    check("never_we_and_re", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
